// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_decoder
// Brief    : TMDS symbol decoder with control-token word alignment / bitslip.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_decoder #(
    parameter int CTL_RUN      = 8,
    parameter int TIMEOUT      = 1024,
    parameter int SLIP_HOLDOFF = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] tmds_in,
    output logic [7:0] vd,
    output logic [1:0] cd,
    output logic       vde,
    output logic       locked,
    output logic       bitslip
);
    localparam int c_cnt_w  = $clog2(TIMEOUT) + 1;
    localparam int c_hold_w = $clog2(SLIP_HOLDOFF) + 1;

    localparam logic [c_cnt_w-1:0]  c_run_max  = c_cnt_w'(CTL_RUN);
    localparam logic [c_cnt_w-1:0]  c_idle_max = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(SLIP_HOLDOFF - 1);

    localparam logic [1:0] c_search    = 2'd0;
    localparam logic [1:0] c_slip_wait = 2'd1;
    localparam logic [1:0] c_locked    = 2'd2;

    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_run_cnt;
    logic [c_cnt_w-1:0]  r_idle_cnt;
    logic [c_hold_w-1:0] r_hold_cnt;

    logic                w_is_tok;
    logic [1:0]          w_tok_cd;
    logic [7:0]          w_q;
    logic [7:0]          w_vd;
    logic [c_cnt_w-1:0]  w_run_next;
    logic                w_run_hit;
    logic                w_timeout;

    always_comb begin
        w_is_tok = 1'b1;
        w_tok_cd = 2'b00;
        case (tmds_in)
            10'b1101010100: w_tok_cd = 2'b00;
            10'b0010101011: w_tok_cd = 2'b01;
            10'b0101010100: w_tok_cd = 2'b10;
            10'b1010101011: w_tok_cd = 2'b11;
            default:        w_is_tok = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    assign w_q  = tmds_in[7:0] ^ {8{tmds_in[9]}};
    assign w_vd = {(w_q[7:1] ^ w_q[6:0]) ^ {7{~tmds_in[8]}}, w_q[0]};

    assign w_run_next = !w_is_tok                ? '0 :
                        (r_run_cnt == c_run_max) ? c_run_max :
                                                   r_run_cnt + 1'b1;
    assign w_run_hit  = (w_run_next == c_run_max);
    assign w_timeout  = (r_idle_cnt == c_idle_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            vd  <= 8'h00;
            cd  <= 2'b00;
            vde <= 1'b0;
        end else if (w_is_tok) begin
            vd  <= 8'h00;
            cd  <= w_tok_cd;
            vde <= 1'b0;
        end else begin
            vd  <= w_vd;
            vde <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_search;
            r_run_cnt  <= '0;
            r_idle_cnt <= '0;
            r_hold_cnt <= '0;
            bitslip    <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            case (r_state)
                c_search: begin
                    // A completed run takes priority over a coincident timeout.
                    if (w_run_hit) begin
                        r_state    <= c_locked;
                        r_run_cnt  <= w_run_next;
                        r_idle_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= c_slip_wait;
                        bitslip    <= 1'b1;
                        r_run_cnt  <= '0;
                        r_idle_cnt <= '0;
                        r_hold_cnt <= '0;
                    end else begin
                        r_run_cnt  <= w_run_next;
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                c_slip_wait: begin
                    r_run_cnt  <= '0;
                    r_idle_cnt <= '0;
                    if (r_hold_cnt == c_hold_max) begin
                        r_state <= c_search;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                c_locked: begin
                    r_run_cnt <= w_run_next;
                    if (w_run_hit) begin
                        r_idle_cnt <= '0;
                    end else if (w_timeout) begin
                        // Fresh timeout window for SEARCH; no slip on lock loss.
                        r_state    <= c_search;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_search;
                    r_run_cnt  <= '0;
                    r_idle_cnt <= '0;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    assign locked = (r_state == c_locked);

endmodule
`default_nettype wire
